// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: depth/count sizing helpers and the
// per-cycle operation encoding derived from push/pop.
package stack_pkg;

  // Number of entries addressable with an aw-bit index.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Count needs one extra bit so that DEPTH itself is representable.
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

  // Operation requested in a cycle, before full/empty qualification.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  // push+pop on an empty stack has no top to replace, so it degrades to a push.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic empty);
    stack_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = empty ? OP_PUSH : OP_REPLACE;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: WIDTH x DEPTH array, synchronous write, asynchronous read.
module stack_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: one word per clock when enabled.
  // NOTE: the array has no reset branch; clearing it would force flops instead
  // of RAM, and the control logic never exposes an unwritten entry anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with zero-latency top-of-stack read, push/pop/replace
// operations, occupancy flags and sticky overflow/underflow error flags.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = depth_of(ADDR_WIDTH) - 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [WIDTH-1:0]                   w_data,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               err_clr,
  output logic [WIDTH-1:0]                   r_data,
  output logic [count_width(ADDR_WIDTH)-1:0] count,
  output logic                               empty,
  output logic                               full,
  output logic                               almost_full,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);

  localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0]         CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  stack_op_e             op;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] top_idx;

  // Flags come from the count register alone, never from this cycle's request.
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign almost_full = (count >= AF_CNT);

  // Top entry sits at count-1; at count == DEPTH the low bits wrap to DEPTH-1.
  assign top_idx = count[ADDR_WIDTH-1:0] - IDX_ONE;

  assign op      = decode_op(push, pop, empty);
  assign ovf_evt = (op == OP_PUSH) && full;
  assign unf_evt = (op == OP_POP) && empty;

  // Select the RAM write: a fresh push lands above the top, a replace on it.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    we    = 1'b0;
    waddr = count[ADDR_WIDTH-1:0];
    case (op)
      OP_PUSH: we = !full;
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = top_idx;
      end
      default: ;
    endcase
  end

  stack_ram #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(w_data),
    .raddr(top_idx),
    .rdata(r_data)
  );

  // Occupancy counter and sticky error flags; an error in the same cycle as
  // err_clr keeps its flag set.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: if (!full)  count <= count + CNT_ONE;
        OP_POP:  if (!empty) count <= count - CNT_ONE;
        default: ;
      endcase
      overflow  <= ovf_evt | (overflow  & ~err_clr);
      underflow <= unf_evt | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (WIDTH=8, ADDR_WIDTH=2, AF_THRESH=3):
// directed vector table, a mid-sequence async reset, then random traffic
// against a queue-based reference model.
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] w_data;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] r_data;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  lifo_stack #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .w_data     (w_data),
    .push       (push),
    .pop        (pop),
    .err_clr    (err_clr),
    .r_data     (r_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] wd;
    logic [2:0] cnt;
    logic       chk_rd;
    logic [7:0] rd;
    logic       em;
    logic       fu;
    logic       af;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input bit chk_rd,
                           input int rd, input bit em, input bit fu,
                           input bit af, input bit ov, input bit un);
    check({tag, ".count"}, 32'(count), cnt);
    if (chk_rd) check({tag, ".r_data"}, 32'(r_data), rd);
    check({tag, ".empty"}, 32'(empty), 32'(em));
    check({tag, ".full"}, 32'(full), 32'(fu));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    check({tag, ".overflow"}, 32'(overflow), 32'(ov));
    check({tag, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  task automatic drive(input logic pu, input logic po, input logic cl,
                       input logic [7:0] wd);
    push    = pu;
    pop     = po;
    err_clr = cl;
    w_data  = wd;
  endtask

  // Reference model state for the random phase.
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_unf;

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 1, 0, 0, 0, 0);
    reset_n = 1'b1;

    //                push pop clr wd     cnt chk rd    em fu af ov un
    vq.push_back('{1, 0, 0, 8'h11, 3'd1, 1, 8'h11, 0, 0, 0, 0, 0});
    vq.push_back('{1, 0, 0, 8'h22, 3'd2, 1, 8'h22, 0, 0, 0, 0, 0});
    vq.push_back('{1, 0, 0, 8'h33, 3'd3, 1, 8'h33, 0, 0, 1, 0, 0});
    vq.push_back('{1, 0, 0, 8'h44, 3'd4, 1, 8'h44, 0, 1, 1, 0, 0});
    vq.push_back('{1, 0, 0, 8'h55, 3'd4, 1, 8'h44, 0, 1, 1, 1, 0});
    vq.push_back('{0, 0, 0, 8'h00, 3'd4, 1, 8'h44, 0, 1, 1, 1, 0});
    vq.push_back('{0, 0, 1, 8'h00, 3'd4, 1, 8'h44, 0, 1, 1, 0, 0});
    vq.push_back('{1, 1, 0, 8'hBB, 3'd4, 1, 8'hBB, 0, 1, 1, 0, 0});
    vq.push_back('{0, 1, 0, 8'h00, 3'd3, 1, 8'h33, 0, 0, 1, 0, 0});
    vq.push_back('{0, 1, 0, 8'h00, 3'd2, 1, 8'h22, 0, 0, 0, 0, 0});
    vq.push_back('{1, 1, 0, 8'hAA, 3'd2, 1, 8'hAA, 0, 0, 0, 0, 0});
    vq.push_back('{0, 1, 0, 8'h00, 3'd1, 1, 8'h11, 0, 0, 0, 0, 0});
    vq.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 8'h00, 1, 0, 0, 0, 0});
    vq.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 8'h00, 1, 0, 0, 0, 1});
    vq.push_back('{0, 1, 1, 8'h00, 3'd0, 0, 8'h00, 1, 0, 0, 0, 1});
    vq.push_back('{0, 0, 1, 8'h00, 3'd0, 0, 8'h00, 1, 0, 0, 0, 0});
    vq.push_back('{1, 1, 0, 8'h77, 3'd1, 1, 8'h77, 0, 0, 0, 0, 0});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].push, vq[i].pop, vq[i].clr, vq[i].wd);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), int'(vq[i].cnt), vq[i].chk_rd,
                int'(vq[i].rd), vq[i].em, vq[i].fu, vq[i].af, vq[i].ov,
                vq[i].un);
    end

    // Fill to full, overflow, pop back to 3, then reset asynchronously.
    foreach (vq[i]) ;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 8'(8'hC0 + i));
      @(posedge clk);
      #1;
    end
    drive(1, 0, 0, 8'hEE);
    @(posedge clk);
    #1;
    drive(0, 1, 0, 8'h00);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 8'h00);
    check_all("pre_rst", 3, 1, 8'hC1, 0, 0, 1, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1, 0, 0, 8'h99);
    @(posedge clk);
    #1;
    check_all("post_rst", 1, 1, 8'h99, 0, 0, 0, 0, 0);

    // Random traffic against a queue model.
    q = '{8'h99};
    m_ovf = 0;
    m_unf = 0;
    for (int n = 0; n < 400; n++) begin
      logic pu, po, cl;
      logic [7:0] wd;
      int bias;
      bias = (n / 50) % 2;
      pu = ($urandom_range(0, 9) < (bias ? 7 : 3));
      po = ($urandom_range(0, 9) < (bias ? 3 : 7));
      cl = ($urandom_range(0, 9) == 0);
      wd = 8'($urandom);
      drive(pu, po, cl, wd);

      if (cl) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (pu && po) begin
        if (q.size() == 0) q.push_back(wd);
        else q[q.size()-1] = wd;
      end else if (pu) begin
        if (q.size() == DEPTH) m_ovf = 1;
        else q.push_back(wd);
      end else if (po) begin
        if (q.size() == 0) m_unf = 1;
        else void'(q.pop_back());
      end

      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", n), q.size(), q.size() != 0,
                (q.size() != 0) ? int'(q[q.size()-1]) : 0, q.size() == 0,
                q.size() == DEPTH, q.size() >= AF, m_ovf, m_unf);
    end

    drive(0, 0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full threshold in entries.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port w_data, input, WIDTH: word to push or to replace the top entry.
REQ-007 SHALL have port push, input, 1: push request for this cycle.
REQ-008 SHALL have port pop, input, 1: pop request for this cycle.
REQ-009 SHALL have port err_clr, input, 1: clears the sticky error flags.
REQ-010 SHALL have port r_data, output, WIDTH: current top-of-stack word.
REQ-011 SHALL have port count, output, ADDR_WIDTH+1: number of occupied entries, 0..DEPTH.
REQ-012 SHALL have port empty, output, 1: high when count == 0.
REQ-013 SHALL have port full, output, 1: high when count == DEPTH.
REQ-014 SHALL have port almost_full, output, 1: high when count >= AF_THRESH.
REQ-015 SHALL have port overflow, output, 1: sticky flag for a push rejected while full.
REQ-016 SHALL have port underflow, output, 1: sticky flag for a pop rejected while empty.

Function
REQ-017 SHALL give all DEPTH entries as usable capacity; full asserts only at count == DEPTH.
REQ-018 SHALL drive r_data combinationally as mem[count-1] with zero read latency; r_data is don't-care while empty.
REQ-019 SHALL, on push=1, pop=0, not full: write w_data to mem[count] and increment count; the new word appears on r_data in the next cycle.
REQ-020 SHALL, on push=1, pop=0, full: leave memory and count unchanged and set overflow.
REQ-021 SHALL, on pop=1, push=0, not empty: decrement count; the word below the popped one appears on r_data in the next cycle.
REQ-022 SHALL, on pop=1, push=0, empty: leave state unchanged and set underflow.
REQ-023 SHALL, on push=1, pop=1, not empty, including full: replace the top entry by writing w_data to mem[count-1], leave count unchanged, and set no error.
REQ-024 SHALL, on push=1, pop=1, empty: behave as a plain push (count becomes 1) and set no underflow.
REQ-025 SHALL derive empty, full and almost_full combinationally from the count register only; they do not depend on the current push or pop.
REQ-026 SHALL clear both sticky flags on err_clr=1; if an error occurs in the same cycle, that flag is set (set wins over clear).
REQ-027 SHALL compute the count arithmetic in ADDR_WIDTH+1 bits and address the memory with the low ADDR_WIDTH bits, so count never wraps past 0 or DEPTH.

Reset
REQ-028 SHALL, on reset_n low, immediately set count=0, overflow=0 and underflow=0, giving empty=1, full=0 and almost_full=0 (almost_full=1 if AF_THRESH == 0).
REQ-029 SHALL NOT reset the memory contents; stale data is unreachable after reset because count=0.
REQ-030 SHALL abandon any operation in progress when reset asserts; the first operation after reset release behaves as on an empty stack.

Structure
REQ-031 SHALL place the DEPTH computation, the count width (ADDR_WIDTH+1) and the push/pop operation encoding (IDLE, PUSH, POP, REPLACE) in a shared package stack_pkg.
REQ-032 SHALL implement the storage as one sub-module, stack_ram: synchronous write, asynchronous read, WIDTH x DEPTH, with no reset.
REQ-033 SHALL hold all control state (count and the sticky flags) in lifo_stack itself.

Verification (WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_THRESH=3)
REQ-034 Push 0x11, 0x22, 0x33, 0x44 -> count 1..4; almost_full rises at count=3; full=1 at count=4; r_data=0x44.
REQ-035 Push 0x55 while full -> count stays 4, r_data stays 0x44, overflow=1 and held; err_clr -> overflow=0.
REQ-036 Pop x4 from 0x11..0x44 -> r_data sequence 0x33, 0x22, 0x11, then empty=1; a fifth pop -> underflow=1 and count=0.
REQ-037 With count=2 and top 0x22, push=pop=1 with w_data=0xAA -> count=2, r_data=0xAA; repeat at full -> full stays 1 and no overflow.
REQ-038 push=pop=1 while empty, w_data=0x77 -> count=1, r_data=0x77, underflow=0.
REQ-039 Assert reset_n mid-sequence at count=3 with overflow=1 -> count=0, empty=1 and overflow=0 without waiting for a clock edge; then push 0x99 -> r_data=0x99.
